// File: rtl/ntt_pkg.sv
// Shared definitions for the NTT command dispatcher: command field layout,
// special opcode/target codes and the dispatcher FSM state type.
package ntt_pkg;

   localparam int CMD_W = 64;

   // Command field positions
   localparam int OPCODE_MSB = 63;
   localparam int OPCODE_LSB = 56;
   localparam int SLOT_MSB   = 55;
   localparam int SLOT_LSB   = 52;
   localparam int TARGET_MSB = 51;
   localparam int TARGET_LSB = 48;
   localparam int DMA_MSB    = 47;
   localparam int DMA_LSB    = 0;

   localparam logic [7:0] OP_BARRIER = 8'hFF;
   localparam logic [3:0] TARGET_ANY = 4'hF;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ISSUE   = 2'd1,
      ST_BARRIER = 2'd2
   } disp_state_e;

   // State implied by a FIFO head: nothing queued, a barrier, or a normal command.
   function automatic disp_state_e head_state(input logic empty, input logic [7:0] opcode);
      if (empty) return ST_IDLE;
      if (opcode == OP_BARRIER) return ST_BARRIER;
      return ST_ISSUE;
   endfunction

endpackage

// File: rtl/ntt_cmd_fifo.sv
// Synchronous show-ahead FIFO. Besides the current head it exposes the head and
// emptiness that will hold after the coming edge, so a consumer FSM can register
// a state that always matches the entry it is looking at.
module ntt_cmd_fifo #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   push,
   input  logic [WIDTH-1:0]       wr_data,
   input  logic                   pop,
   output logic [WIDTH-1:0]       head,
   output logic [WIDTH-1:0]       nxt_head,
   output logic                   nxt_empty,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
   localparam logic [AW:0] ONE_C   = (AW+1)'(1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q, count_d;
   logic             push_ok, pop_ok;

   assign full    = (count_q == DEPTH_C);
   assign empty   = (count_q == '0);
   assign count   = count_q;
   assign head    = mem_q[rd_ptr_q];
   assign push_ok = push & ~full;
   assign pop_ok  = pop & ~empty;

   // Next storage, pointers, occupancy and look-ahead head.
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_ok) begin
         mem_d[wr_ptr_q] = wr_data;
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop_ok) rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
      nxt_empty = (count_d == '0);
      nxt_head  = mem_q[rd_ptr_d];
      // The pushed word becomes the head when nothing else remains queued.
      if (push_ok && (empty || (pop_ok && count_q == ONE_C))) nxt_head = wr_data;
   end

   // Storage array; contents are qualified by count, so no reset is needed.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   // Pointer and occupancy registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/ntt_cmd_dispatcher.sv
// Command dispatcher for the NTT cores: queues host commands and issues each as
// a one-cycle start pulse to an idle core (round-robin or named), honours
// barriers, and counts issued and dropped commands.
//
// Host handshake: a command is transferred on every rising edge where
// cmd_in_valid and cmd_in_ready are both high; cmd_in_ready depends only on
// internal state (never on cmd_in_valid), and the host holds data stable while
// valid is high and ready is low.
module ntt_cmd_dispatcher
   import ntt_pkg::*;
#(
   parameter int NUM_CORES  = 4,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 cmd_in_valid,
   output logic                 cmd_in_ready,
   input  logic [63:0]          cmd_in_data,
   output logic [NUM_CORES-1:0] core_start,
   output logic [63:0]          core_cmd_data,
   input  logic [NUM_CORES-1:0] core_ready,
   output logic                 busy,
   output logic [31:0]          issued_count,
   output logic                 err_pulse,
   output logic [15:0]          err_count
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   disp_state_e          state_q, state_d;
   logic                 ready_en_q, ready_en_d;
   logic [NUM_CORES-1:0] core_start_q, core_start_d;
   logic [NUM_CORES-1:0] holdoff_q, holdoff_d;
   logic [63:0]          core_cmd_data_q, core_cmd_data_d;
   logic [31:0]          issued_count_q, issued_count_d;
   logic                 err_pulse_q, err_pulse_d;
   logic [15:0]          err_count_q, err_count_d;
   logic [3:0]           rr_ptr_q, rr_ptr_d;

   logic [CMD_W-1:0]     fifo_head, fifo_nxt_head;
   logic                 fifo_full, fifo_empty, fifo_nxt_empty;
   logic [CW-1:0]        fifo_count;
   logic                 fifo_pop;
   logic [15:0]          elig_ext;
   logic [3:0]           head_target;
   logic                 any_found, issue_en;
   logic [3:0]           any_idx, issue_idx;
   logic                 all_idle;

   assign cmd_in_ready = ready_en_q & ~fifo_full;
   assign head_target  = fifo_head[TARGET_MSB:TARGET_LSB];
   assign elig_ext     = 16'(core_ready & ~holdoff_q);
   assign all_idle     = (&core_ready) && (holdoff_q == '0);

   ntt_cmd_fifo #(
      .WIDTH (CMD_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (cmd_in_valid & cmd_in_ready),
      .wr_data   (cmd_in_data),
      .pop       (fifo_pop),
      .head      (fifo_head),
      .nxt_head  (fifo_nxt_head),
      .nxt_empty (fifo_nxt_empty),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   // Round-robin search: first eligible core at or above rr_ptr, wrapping.
   always_comb begin
      any_found = 1'b0;
      any_idx   = '0;
      for (int i = 0; i < NUM_CORES; i++) begin
         if (!any_found && elig_ext[4'((int'(rr_ptr_q) + i) % NUM_CORES)]) begin
            any_found = 1'b1;
            any_idx   = 4'((int'(rr_ptr_q) + i) % NUM_CORES);
         end
      end
   end

   // FSM next state, issue decision and counter updates.
   always_comb begin
      fifo_pop        = 1'b0;
      issue_en        = 1'b0;
      issue_idx       = '0;
      ready_en_d      = 1'b1;
      core_start_d    = '0;
      holdoff_d       = '0;
      core_cmd_data_d = core_cmd_data_q;
      issued_count_d  = issued_count_q;
      err_pulse_d     = 1'b0;
      err_count_d     = err_count_q;
      rr_ptr_d        = rr_ptr_q;

      if (!fifo_empty) begin
         case (state_q)
            ST_ISSUE: begin
               if (head_target == TARGET_ANY) begin
                  if (any_found) begin
                     issue_en  = 1'b1;
                     issue_idx = any_idx;
                     rr_ptr_d  = 4'((int'(any_idx) + 1) % NUM_CORES);
                  end
               end else if (int'(head_target) < NUM_CORES) begin
                  if (elig_ext[head_target]) begin
                     issue_en  = 1'b1;
                     issue_idx = head_target;
                  end
               end else begin
                  // Illegal target: drop the command and report it.
                  fifo_pop    = 1'b1;
                  err_pulse_d = 1'b1;
                  if (err_count_q != 16'hFFFF) err_count_d = err_count_q + 16'd1;
               end
            end
            ST_BARRIER: begin
               if (all_idle) fifo_pop = 1'b1;
            end
            default: ;
         endcase
      end

      if (issue_en) begin
         fifo_pop        = 1'b1;
         core_start_d    = NUM_CORES'(16'd1 << issue_idx);
         holdoff_d       = NUM_CORES'(16'd1 << issue_idx);
         core_cmd_data_d = fifo_head;
         issued_count_d  = issued_count_q + 32'd1;
      end

      // State always tracks the head that will be visible after this edge.
      state_d = head_state(fifo_nxt_empty, fifo_nxt_head[OPCODE_MSB:OPCODE_LSB]);
   end

   // State, output and counter registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q         <= ST_IDLE;
         ready_en_q      <= 1'b0;
         core_start_q    <= '0;
         holdoff_q       <= '0;
         core_cmd_data_q <= '0;
         issued_count_q  <= '0;
         err_pulse_q     <= 1'b0;
         err_count_q     <= '0;
         rr_ptr_q        <= '0;
      end else begin
         state_q         <= state_d;
         ready_en_q      <= ready_en_d;
         core_start_q    <= core_start_d;
         holdoff_q       <= holdoff_d;
         core_cmd_data_q <= core_cmd_data_d;
         issued_count_q  <= issued_count_d;
         err_pulse_q     <= err_pulse_d;
         err_count_q     <= err_count_d;
         rr_ptr_q        <= rr_ptr_d;
      end
   end

   assign core_start    = core_start_q;
   assign core_cmd_data = core_cmd_data_q;
   assign issued_count  = issued_count_q;
   assign err_pulse     = err_pulse_q;
   assign err_count     = err_count_q;
   assign busy          = (fifo_count != '0) || (state_q != ST_IDLE);

endmodule

// File: doc/ntt_cmd_dispatcher.md
# ntt_cmd_dispatcher

Upstream feeder for the NTT cores. Buffers 64-bit host commands in a FIFO and issues each one as a single-cycle `start` pulse with `cmd_data` to an idle core. The core is either chosen round-robin or named in the command. Also implements a BARRIER command that stalls issue until every core is idle, and keeps issue and error counters for the host.

## Interface
- `NUM_CORES`, default 4: number of NTT cores driven; legal range 1..15.
- `FIFO_DEPTH`, default 8: command FIFO entries; power of two, at least 2.
- `clk`  in  1: clock; all logic on the rising edge.
- `rst_n`  in  1: reset; synchronous and active-low.
- `cmd_in_valid`  in  1: host command valid.
- `cmd_in_ready`  out  1: FIFO can accept; equals not-full.
- `cmd_in_data`  in  64: command. Bits [63:56] opcode, [55:52] slot, [51:48] target, [47:0] DMA address.
- `core_start`  out  NUM_CORES: one-hot start pulse, registered.
- `core_cmd_data`  out  64: command for the pulsed core, registered; valid only while a `core_start` bit is high.
- `core_ready`  in  NUM_CORES: per-core ready.
- `busy`  out  1: FIFO non-empty, or FSM not in IDLE.
- `issued_count`  out  32: commands issued to cores; wraps modulo 2^32.
- `err_pulse`  out  1: one-cycle pulse when a command with an illegal target is dropped.
- `err_count`  out  16: dropped commands; saturates at 0xFFFF.

## Operation
- **Push.** A push occurs when `cmd_in_valid` and `cmd_in_ready` are both high at an edge.
  - When the FIFO is full, `cmd_in_ready` is low, even if a pop happens in the same cycle.
  - Simultaneous push and pop on a non-full, non-empty FIFO leaves the count unchanged.
- **Head.** The FIFO is show-ahead: the head entry is visible combinationally.
- **Target decode** on the head entry:
  - target = 0xF: any core.
  - target < NUM_CORES: that core only.
  - any other target: illegal.
- **Core eligibility.** Core k is eligible when `core_ready[k]` is high and its holdoff bit is clear.
  - The holdoff bit is set at the edge that issues to core k and cleared at the following edge.
  - Core contract: `core_ready` deasserts no later than the cycle after `start` is sampled.
- **FSM states:**
  - IDLE: FIFO empty.
  - ISSUE: head is a normal command.
  - BARRIER: head opcode is 0xFF.
- **In ISSUE:**
  - Any-core command: search from `rr_ptr` upward, with wrap-around, for the first eligible core.
  - Targeted command: wait only for the named core.
  - On issue: set that core's `core_start` bit, load `core_cmd_data` with the head entry unmodified, pop the FIFO, and increment `issued_count`.
  - `rr_ptr` becomes chosen+1 modulo NUM_CORES after an any-core issue. Targeted issues do not move `rr_ptr`.
  - Illegal target: pop without issuing, pulse `err_pulse`, increment `err_count`. This takes one cycle and issues nothing.
- **In BARRIER:**
  - Pop with no issue on the first edge where all `core_ready` are high and all holdoff bits are clear.
  - A barrier does not count toward `issued_count`.
- **Ordering.** Issue is strictly in order. A blocked head blocks everything behind it.
- **Next state.** After every pop, the next state is recomputed from the new head: IDLE if the FIFO is empty, otherwise ISSUE or BARRIER.

## Timing
- **Reset values**, forced while `rst_n` is low at an edge:
  - `cmd_in_ready` = 0. It rises in the first cycle after reset releases.
  - `core_start` = 0, `core_cmd_data` = 0, `busy` = 0, `issued_count` = 0, `err_pulse` = 0, `err_count` = 0.
  - FIFO emptied, holdoff bits cleared, `rr_ptr` = 0, FSM in IDLE.
- **Reset mid-operation** discards all queued commands. A `core_start` pulse is dropped if reset is sampled at the edge that would register it.
- **Latency.** A command pushed into an empty FIFO at edge E0, with an eligible core, produces `core_start` high from E1 to E2.
- **Throughput.** Up to one issue per cycle. Back-to-back issues to the same core are at least 2 cycles apart because of holdoff.
- **Pulse widths.** `core_start` and `err_pulse` are exactly one cycle wide. At most one `core_start` bit is high per cycle.

## Structure
- Shared package `ntt_pkg` holds:
  - `OP_BARRIER` = 8'hFF and `TARGET_ANY` = 4'hF.
  - Field LSB/MSB constants for opcode, slot, target and DMA address.
  - The FSM state enum.
- Sub-module `ntt_cmd_fifo`: a synchronous show-ahead FIFO, parameterized by width and depth, with full, empty and count outputs.
- Top-level logic: FSM, round-robin selector, holdoff register, counters.

## Test plan
- **Round-robin:** with NUM_CORES=4, all ready, push 4 any-core commands `0x01_0_F_000000001000`..`_004000`. Expect `core_start` = 0001, 0010, 0100, 1000 on consecutive cycles, and `issued_count` = 4.
- **Targeted wait:** target 2 with `core_ready`=1011; raise bit 2 after 5 cycles. Expect the pulse on bit 2 exactly one cycle later, and a later any-core command still waits behind it.
- **Barrier:** push A (target 0), BARRIER, B (target 1) while core 0 stays busy 10 cycles after issue. Expect B is not issued until all ready, and `issued_count` = 2.
- **Illegal target:** push target 0x9 with NUM_CORES=4. Expect `err_pulse` high for 1 cycle, `err_count` = 1, no `core_start`, and the next command issues normally.
- **FIFO full and reset:** with all `core_ready`=0, push 8 commands. Expect `cmd_in_ready`=0 and a 9th push refused. Then assert `rst_n`=0 for 1 cycle: expect `busy`=0 and nothing issued afterwards even with cores ready.
